// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the cacheline port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int c_ADDR_WIDTH = 32;
    localparam int c_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin pick; on a tie the side that did not own
//               the port last time wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic   i_pend_i,
    input  logic   i_pend_d,
    input  owner_t i_last_owner,
    output owner_t o_owner
);

    always_comb begin
        o_owner = OWNER_I;
        if (i_pend_i && i_pend_d) begin
            o_owner = (i_last_owner == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (i_pend_d) begin
            o_owner = OWNER_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serialises I-side and D-side cacheline requests onto a single
//               registered memory port, holding one owner until mem_resp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int LINE_WIDTH = c_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    owner_t                r_last_owner;
    owner_t                w_pick;
    logic                  w_pend_i;
    logic                  w_pend_d;
    logic                  w_grant;

    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [LINE_WIDTH-1:0] w_sel_wdata;
    logic                  w_sel_write;
    logic                  w_sel_read;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [LINE_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_read;
    logic                  r_mem_write;

    assign w_pend_i = i_read | i_write;
    assign w_pend_d = d_read | d_write;

    rr_pick2 u_pick (
        .i_pend_i     (w_pend_i),
        .i_pend_d     (w_pend_d),
        .i_last_owner (r_last_owner),
        .o_owner      (w_pick)
    );

    assign w_sel_addr  = (w_pick == OWNER_D) ? d_addr  : i_addr;
    assign w_sel_wdata = (w_pick == OWNER_D) ? d_wdata : i_wdata;
    assign w_sel_write = (w_pick == OWNER_D) ? d_write : i_write;
    // A side raising both strobes is a protocol error; the write is honoured.
    assign w_sel_read  = ((w_pick == OWNER_D) ? d_read : i_read) & ~w_sel_write;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_i || w_pend_d) begin
                    w_grant     = 1'b1;
                    w_state_nxt = (w_pick == OWNER_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_owner <= OWNER_I;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_owner <= w_pick;
                r_mem_addr   <= w_sel_addr;
                r_mem_wdata  <= w_sel_wdata;
                r_mem_read   <= w_sel_read;
                r_mem_write  <= w_sel_write;
            end else if ((r_state != IDLE) && mem_resp) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;

    // Responses are combinational so the owner sees completion in the resp cycle.
    assign i_resp  = mem_resp & (r_state == SERVE_I);
    assign d_resp  = mem_resp & (r_state == SERVE_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    a_i_rw_exclusive : assert property (@(posedge clk) disable iff (rst) !(i_read && i_write));
    a_d_rw_exclusive : assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench with a transaction-level arbitration model
//               and a latency-programmable memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] i_addr = '0, d_addr = '0, mem_addr;
    logic          i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [LW-1:0] i_wdata = '0, d_wdata = '0, i_rdata, d_rdata, mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          i_resp, d_resp, mem_read, mem_write;
    logic          mem_resp = 1'b0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    txn_t req_i[$], req_d[$];        // requests still to be issued
    txn_t exp_i[$], exp_d[$];        // issued, awaiting completion
    logic [LW-1:0] ref_mem  [logic [AW-1:0]];
    logic [LW-1:0] mem_store[logic [AW-1:0]];

    bit [1:0] act   = '0;
    bit [1:0] done  = '0;
    bit [1:0] owned = '0;
    int  rst_cnt     = 3;
    int  lat_fixed   = 1;
    int  wiggle_rate = 0;
    bit  spur_req    = 0;

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_req(input int s, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        if (s == 0) req_i.push_back(t); else req_d.push_back(t);
    endtask

    task automatic drive_side(input int s, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [LW-1:0] d);
        if (s == 0) begin
            i_read = rd; i_write = wr; i_addr = a; i_wdata = d;
        end else begin
            d_read = rd; d_write = wr; d_addr = d_addr; d_addr = a; d_wdata = d;
        end
    endtask

    task automatic drop_side(input int s);
        if (s == 0) begin i_read = 1'b0; i_write = 1'b0; end
        else begin d_read = 1'b0; d_write = 1'b0; end
    endtask

    // Issue: expected read data comes from the requester's view of memory.
    task automatic issue(input int s);
        txn_t t, e;
        if (s == 0) t = req_i.pop_front(); else t = req_d.pop_front();
        e = t;
        if (t.wr) ref_mem[t.addr] = t.data;
        else e.data = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_line(t.addr);
        if (s == 0) exp_i.push_back(e); else exp_d.push_back(e);
        drive_side(s, !t.wr, t.wr, t.addr, t.data);
    endtask

    // Requester driver
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rst_cnt > 0) begin
                rst = 1'b1;
                rst_cnt--;
                drop_side(0); drop_side(1);
                act = '0;
                continue;
            end
            rst = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (done[s]) begin
                    drop_side(s);
                    act[s]  = 1'b0;
                    done[s] = 1'b0;
                end else if (!act[s] && ((s == 0) ? req_i.size() : req_d.size()) > 0) begin
                    issue(s);
                    act[s] = 1'b1;
                end else if (act[s] && owned[s] && ($urandom_range(0, 99) < wiggle_rate)) begin
                    if (s == 0) begin i_addr = $urandom; i_wdata = rnd_line(); end
                    else begin d_addr = $urandom; d_wdata = rnd_line(); end
                end
            end
        end
    end

    // Memory model, reference arbitration model and scoreboard monitor
    int   m_state = 0;   // 0 idle, 1 serving I, 2 serving D
    int   m_last  = 0;   // 0 I, 1 D
    bit   p_pi = 0, p_pd = 0, p_resp = 0, p_rst = 1;
    txn_t cur;
    bit   mm_busy = 0, mm_done = 0;
    int   mm_cnt = 0, mm_lat = 0;

    initial begin
        bit grant_new, was_rst, ei, ed;
        int own;
        forever begin
            @(negedge clk);
            grant_new = 0;
            was_rst   = p_rst;
            if (p_rst) begin
                m_state = 0; m_last = 0;
            end else if (m_state == 0) begin
                if (p_pi || p_pd) begin
                    own       = (p_pi && p_pd) ? (1 - m_last) : (p_pd ? 1 : 0);
                    m_state   = own + 1;
                    m_last    = own;
                    grant_new = 1;
                end
            end else if (p_resp) begin
                m_state = 0;
            end

            mem_resp = 1'b0;
            if (rst || !(mem_read || mem_write)) begin
                mm_busy = 0;
                if (spur_req && !rst) begin
                    mem_resp  = 1'b1;
                    mem_rdata = rnd_line();
                    spur_req  = 0;
                end
            end else begin
                if (!mm_busy) begin
                    mm_busy = 1; mm_done = 0; mm_cnt = 0;
                    mm_lat  = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
                end
                if (!mm_done) begin
                    if (mm_cnt == mm_lat) begin
                        mem_resp = 1'b1;
                        mm_done  = 1;
                        if (mem_write) mem_store[mem_addr] = mem_wdata;
                        else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_line(mem_addr);
                    end else begin
                        mm_cnt++;
                    end
                end
            end
            #1;

            ei = mem_resp && (m_state == 1);
            ed = mem_resp && (m_state == 2);
            check("resp_i_d", LW'({i_resp, d_resp}), LW'({ei, ed}));

            if (was_rst) begin
                check("reset_addr", LW'(mem_addr), '0);
                check("reset_wdata", mem_wdata, '0);
            end

            if (grant_new) begin
                own = m_state - 1;
                if (((own == 0) ? exp_i.size() : exp_d.size()) == 0) begin
                    check("grant_has_request", LW'(0), LW'(1));
                    m_state = 0;
                end else begin
                    cur        = (own == 0) ? exp_i[0] : exp_d[0];
                    owned[own] = 1'b1;
                    check("grant_op_addr", LW'({mem_write, mem_read, mem_addr}), LW'({cur.wr, !cur.wr, cur.addr}));
                    if (cur.wr) check("grant_wdata", mem_wdata, cur.data);
                end
            end else if (m_state != 0) begin
                check("hold_op_addr", LW'({mem_write, mem_read, mem_addr}), LW'({cur.wr, !cur.wr, cur.addr}));
                if (cur.wr) check("hold_wdata", mem_wdata, cur.data);
            end else begin
                check("idle_strobes", LW'({mem_write, mem_read}), '0);
            end

            if (ei || ed) begin
                own = ei ? 0 : 1;
                if (!cur.wr) check(ei ? "i_rdata" : "d_rdata", ei ? i_rdata : d_rdata, cur.data);
                if (own == 0) void'(exp_i.pop_front()); else void'(exp_d.pop_front());
                owned[own] = 1'b0;
                done[own]  = 1'b1;
            end

            if (rst) begin
                exp_i.delete(); exp_d.delete();
                owned = '0; done = '0;
            end

            p_pi   = i_read | i_write;
            p_pd   = d_read | d_write;
            p_resp = mem_resp;
            p_rst  = rst;
        end
    end

    task automatic wait_quiet(input int max_cycles, input string tag);
        int n = 0;
        while ((req_i.size() + req_d.size() + exp_i.size() + exp_d.size()) != 0 || act != 0 || rst_cnt != 0) begin
            @(posedge clk);
            n++;
            if (n > max_cycles) begin
                check({"timeout_", tag}, LW'(n), LW'(max_cycles));
                req_i.delete(); req_d.delete();
                rst_cnt = 1;
                n = 0;
                repeat (4) @(posedge clk);
                break;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n;
        // Tie on the first cycle out of reset: D must win
        push_req(0, 1'b0, 32'h0000_0100, '0);
        push_req(1, 1'b1, 32'h0000_0200, rnd_line());
        wait_quiet(100, "tie_after_reset");

        lat_fixed = 3;
        push_req(0, 1'b0, 32'h0000_1000, '0);
        wait_quiet(100, "single_i_read");

        lat_fixed = 1;
        push_req(0, 1'b1, 32'h0000_1020, rnd_line());
        push_req(0, 1'b0, 32'h0000_1020, '0);
        push_req(1, 1'b1, 32'h0000_8000, rnd_line());
        push_req(1, 1'b0, 32'h0000_8000, '0);
        wait_quiet(100, "alternation");

        lat_fixed = 0;
        push_req(1, 1'b0, 32'h0000_0200, '0);
        wait_quiet(100, "zero_wait");

        // Reset in the second SERVE_I cycle
        lat_fixed = 10;
        push_req(0, 1'b0, 32'h0000_1040, '0);
        n = 0;
        while (!owned[0] && n < 20) begin @(negedge clk); n++; end
        check("reset_test_granted", LW'(owned[0]), LW'(1));
        rst_cnt = 1;
        wait_quiet(100, "mid_reset");

        lat_fixed = 2;
        push_req(0, 1'b0, 32'h0000_1040, '0);
        push_req(1, 1'b0, 32'h0000_8000, '0);
        wait_quiet(100, "tie_after_mid_reset");

        spur_req = 1;
        repeat (3) @(posedge clk);
        wiggle_rate = 100;
        lat_fixed   = 3;
        push_req(1, 1'b1, 32'h0000_8020, rnd_line());
        push_req(1, 1'b0, 32'h0000_8020, '0);
        wait_quiet(100, "spurious_and_wiggle");

        lat_fixed   = -1;
        wiggle_rate = 30;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 1) == 0)
                push_req(0, 1'($urandom_range(0, 1)), 32'h0000_1000 + 32'($urandom_range(0, 7)) * 32, rnd_line());
            else
                push_req(1, 1'($urandom_range(0, 1)), 32'h0000_8000 + 32'($urandom_range(0, 7)) * 32, rnd_line());
        end
        wait_quiet(3000, "random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
